// File: rtl/i2c_seq_pkg.sv
// Shared definitions for the I2C init sequencer: state encoding,
// configuration-entry layout and the byte-width clamp helper.
package i2c_seq_pkg;

  localparam int ENTRY_W = 48;

  // Bit positions of the fields inside one 48-bit table entry
  localparam int REG_MSB   = 47;
  localparam int REG_LSB   = 40;
  localparam int WIDTH_MSB = 35;
  localparam int WIDTH_LSB = 32;
  localparam int DATA_MSB  = 31;
  localparam int DATA_LSB  = 0;

  typedef enum logic [3:0] {
    IDLE,
    FLUSH,
    LOAD,
    START,
    WAIT,
    FAIL,
    GAP,
    DONE,
    ERROR
  } seq_state_t;

  // The engine takes at most four data bytes, so larger widths saturate at 4
  function automatic logic [2:0] clamp_width(input logic [3:0] n);
    return (n > 4'd4) ? 3'd4 : n[2:0];
  endfunction

endpackage

// File: rtl/i2c_init_rom.sv
// Sensor configuration table: one combinational lookup per entry index.
// A byte width of zero terminates the table.
module i2c_init_rom
  import i2c_seq_pkg::*;
(
  input  logic [3:0]         index,
  output logic [ENTRY_W-1:0] entry
);

  // Table contents: {reg address, 4'h0, byte width, data}
  always_comb begin
    entry = '0;
    case (index)
      4'd0:    entry = {8'h10, 4'h0, 4'd1, 32'h0000_00A5};
      4'd1:    entry = {8'h20, 4'h0, 4'd2, 32'h0000_BEEF};
      4'd2:    entry = {8'h30, 4'h0, 4'd4, 32'h1234_5678};
      default: entry = '0;
    endcase
  end

endmodule

// File: rtl/i2c_init_sequencer.sv
// Walks the configuration table through the I2C register-write engine:
// flush and fill the engine FIFO, pulse start, wait for done/failure,
// retry failures, space entries apart and report done/error status.
// A watchdog covers the engine silently abandoning a transfer.
module i2c_init_sequencer
  import i2c_seq_pkg::*;
#(
  parameter logic [6:0] DEV_ADDRESS     = 7'h29,
  parameter int         NUM_ENTRIES     = 8,
  parameter int         MAX_RETRIES     = 3,
  parameter int         GAP_CYCLES      = 1000,
  parameter int         WATCHDOG_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_start,
  output logic       init_busy,
  output logic       init_done,
  output logic       init_error,
  output logic [3:0] failed_index,
  output logic [6:0] wr_dev_address,
  output logic [7:0] wr_reg_address,
  output logic [3:0] wr_byte_width,
  output logic       wr_start,
  output logic [7:0] wr_data,
  output logic       wr_fifo_wr_en,
  output logic       wr_fifo_reset,
  input  logic       wr_fifo_full,
  input  logic       wr_done,
  input  logic       wr_failure
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int WD_W  = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;

  localparam logic [GAP_W-1:0] GAP_LAST      = GAP_W'(GAP_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST       = WD_W'(WATCHDOG_CYCLES - 1);
  localparam logic [1:0]       RETRY_LIMIT   = 2'(MAX_RETRIES);
  localparam logic [4:0]       ENTRY_COUNT   = 5'(NUM_ENTRIES);

  seq_state_t         state_q, state_d;
  logic [3:0]         index_q, index_d;
  logic [1:0]         retry_q, retry_d;
  logic [2:0]         byte_cnt_q, byte_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [3:0]         failed_q, failed_d;

  logic [ENTRY_W-1:0] cur_entry;
  logic [ENTRY_W-1:0] next_entry;
  logic [3:0]         next_index;
  logic [4:0]         index_plus1;
  logic [2:0]         cur_n;
  logic [2:0]         next_n;
  logic [31:0]        cur_data;
  logic [7:0]         load_byte;
  logic               active;
  logic               unused_entry_bits;

  assign next_index  = index_q + 4'd1;
  assign index_plus1 = {1'b0, index_q} + 5'd1;

  i2c_init_rom u_rom_cur (
    .index (index_q),
    .entry (cur_entry)
  );

  i2c_init_rom u_rom_next (
    .index (next_index),
    .entry (next_entry)
  );

  assign cur_n    = clamp_width(cur_entry[WIDTH_MSB:WIDTH_LSB]);
  assign next_n   = clamp_width(next_entry[WIDTH_MSB:WIDTH_LSB]);
  assign cur_data = cur_entry[DATA_MSB:DATA_LSB];

  assign unused_entry_bits = ^{cur_entry[39:36], next_entry[47:36], next_entry[31:0]};

  // Pick the byte to load: the counter counts down from n, so the
  // most-significant byte of the active data goes out first
  always_comb begin
    load_byte = cur_data[7:0];
    case (byte_cnt_q)
      3'd4:    load_byte = cur_data[31:24];
      3'd3:    load_byte = cur_data[23:16];
      3'd2:    load_byte = cur_data[15:8];
      default: load_byte = cur_data[7:0];
    endcase
  end

  // Next-state, counter updates and engine-facing outputs
  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    retry_d       = retry_q;
    byte_cnt_d    = byte_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    wdog_d        = wdog_q;
    done_d        = done_q;
    error_d       = error_q;
    failed_d      = failed_q;
    wr_fifo_reset = 1'b0;
    wr_fifo_wr_en = 1'b0;
    wr_start      = 1'b0;
    wr_data       = 8'h00;

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (init_start) begin
          state_d    = FLUSH;
          index_d    = 4'd0;
          retry_d    = 2'd0;
          byte_cnt_d = 3'd0;
          gap_cnt_d  = '0;
          wdog_d     = '0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          failed_d   = 4'd0;
        end
      end
      FLUSH: begin
        wr_fifo_reset = 1'b1;
        byte_cnt_d    = cur_n;
        if (cur_n == 3'd0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (byte_cnt_q == 3'd0) begin
          state_d = START;
        end else if (!wr_fifo_full) begin
          wr_fifo_wr_en = 1'b1;
          wr_data       = load_byte;
          byte_cnt_d    = byte_cnt_q - 3'd1;
          if (byte_cnt_q == 3'd1) begin
            state_d = START;
          end
        end
      end
      START: begin
        wr_start = 1'b1;
        wdog_d   = '0;
        state_d  = WAIT;
      end
      WAIT: begin
        if (wr_failure) begin
          state_d = FAIL;
        end else if (wr_done) begin
          state_d   = GAP;
          gap_cnt_d = '0;
        end else if (wdog_q == WD_LAST) begin
          state_d = FAIL;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      FAIL: begin
        if (retry_q < RETRY_LIMIT) begin
          retry_d = retry_q + 2'd1;
          state_d = FLUSH;
        end else begin
          error_d  = 1'b1;
          failed_d = index_q;
          state_d  = ERROR;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          retry_d   = 2'd0;
          if (index_plus1 == ENTRY_COUNT) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            index_d = next_index;
            if (next_n == 3'd0) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = FLUSH;
            end
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign active         = (state_q != IDLE) && (state_q != DONE) && (state_q != ERROR);
  assign init_busy      = active;
  assign init_done      = done_q;
  assign init_error     = error_q;
  assign failed_index   = failed_q;
  assign wr_dev_address = DEV_ADDRESS;
  assign wr_reg_address = active ? cur_entry[REG_MSB:REG_LSB] : 8'h00;
  assign wr_byte_width  = active ? {1'b0, cur_n} : 4'd0;

  // State, counters and status levels; reset abandons any sequence in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      index_q    <= 4'd0;
      retry_q    <= 2'd0;
      byte_cnt_q <= 3'd0;
      gap_cnt_q  <= '0;
      wdog_q     <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      failed_q   <= 4'd0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      retry_q    <= retry_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      wdog_q     <= wdog_d;
      done_q     <= done_d;
      error_q    <= error_d;
      failed_q   <= failed_d;
    end
  end

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Directed bench for i2c_init_sequencer. Inputs change 1 time unit after
// the rising edge; outputs are checked at the falling edge. A small
// monitor logs FIFO writes, start pulses and FIFO flushes.
module tb_i2c_init_sequencer;

  localparam int GAP = 20;
  localparam int WD  = 200;

  logic       clk = 1'b0;
  logic       reset;
  logic       init_start;
  logic       init_busy;
  logic       init_done;
  logic       init_error;
  logic [3:0] failed_index;
  logic [6:0] wr_dev_address;
  logic [7:0] wr_reg_address;
  logic [3:0] wr_byte_width;
  logic       wr_start;
  logic [7:0] wr_data;
  logic       wr_fifo_wr_en;
  logic       wr_fifo_reset;
  logic       wr_fifo_full;
  logic       wr_done;
  logic       wr_failure;

  int         vectors     = 0;
  int         miscompares = 0;
  int         cyc         = 0;
  int         starts      = 0;
  int         flushes     = 0;
  logic [7:0] writes[$];
  logic [7:0] exp_q[$];

  i2c_init_sequencer #(
    .DEV_ADDRESS     (7'h29),
    .NUM_ENTRIES     (8),
    .MAX_RETRIES     (3),
    .GAP_CYCLES      (GAP),
    .WATCHDOG_CYCLES (WD)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .init_start     (init_start),
    .init_busy      (init_busy),
    .init_done      (init_done),
    .init_error     (init_error),
    .failed_index   (failed_index),
    .wr_dev_address (wr_dev_address),
    .wr_reg_address (wr_reg_address),
    .wr_byte_width  (wr_byte_width),
    .wr_start       (wr_start),
    .wr_data        (wr_data),
    .wr_fifo_wr_en  (wr_fifo_wr_en),
    .wr_fifo_reset  (wr_fifo_reset),
    .wr_fifo_full   (wr_fifo_full),
    .wr_done        (wr_done),
    .wr_failure     (wr_failure)
  );

  always #5 clk = ~clk;

  // Cycle counter used to measure spacing between events
  always @(posedge clk) cyc <= cyc + 1;

  // Log engine-side activity once per cycle, away from the active edge
  always @(negedge clk) begin
    if (wr_fifo_wr_en) writes.push_back(wr_data);
    if (wr_start)      starts++;
    if (wr_fifo_reset) flushes++;
  end

  // Hard stop in case a wait loop is ever broken
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation time limit reached, required completion");
    $fatal(1, "[TB] stopped");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive inputs for the next cycle and return at that cycle's falling edge
  task automatic applyStimulus(input logic start, input logic full, input logic done, input logic fail);
    @(posedge clk);
    #1;
    init_start   = start;
    wr_fifo_full = full;
    wr_done      = done;
    wr_failure   = fail;
    @(negedge clk);
  endtask

  task automatic clearLog();
    writes.delete();
    starts  = 0;
    flushes = 0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy"},     32'(init_busy), 0);
    checkOutput({tag, "_done"},     32'(init_done), 0);
    checkOutput({tag, "_error"},    32'(init_error), 0);
    checkOutput({tag, "_failidx"},  32'(failed_index), 0);
    checkOutput({tag, "_dev"},      32'(wr_dev_address), 32'h29);
    checkOutput({tag, "_reg"},      32'(wr_reg_address), 0);
    checkOutput({tag, "_width"},    32'(wr_byte_width), 0);
    checkOutput({tag, "_start"},    32'(wr_start), 0);
    checkOutput({tag, "_data"},     32'(wr_data), 0);
    checkOutput({tag, "_wr_en"},    32'(wr_fifo_wr_en), 0);
    checkOutput({tag, "_fifo_rst"}, 32'(wr_fifo_reset), 0);
  endtask

  // Pulse init_start and confirm the FLUSH cycle that follows
  task automatic startSeq(output int t);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    t = cyc;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("busy_after_start", 32'(init_busy), 1);
    checkOutput("flush_after_start", 32'(wr_fifo_reset), 1);
  endtask

  task automatic waitStart(output int s);
    int n = 0;
    while (!wr_start && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wr_start_seen", 32'(wr_start), 1);
    s = cyc;
  endtask

  task automatic waitFlush(output int f);
    int n = 0;
    while (!wr_fifo_reset && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wr_fifo_reset_seen", 32'(wr_fifo_reset), 1);
    f = cyc;
  endtask

  task automatic waitStatus();
    int n = 0;
    while (!init_done && !init_error && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("status_reached", 32'(init_done | init_error), 1);
  endtask

  // Engine model: its response is sampled on the 50th (or d-th) rising
  // edge counted from and including the edge that captured wr_start
  task automatic serve(input int d, input logic done, input logic fail,
                       input logic [7:0] exp_reg, input logic [3:0] exp_n, output int s);
    waitStart(s);
    checkOutput("reg_addr_at_start", 32'(wr_reg_address), 32'(exp_reg));
    checkOutput("byte_width_at_start", 32'(wr_byte_width), 32'(exp_n));
    repeat (d - 2) @(negedge clk);
    applyStimulus(1'b0, 1'b0, done, fail);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkWrites();
    checkOutput("write_count", writes.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < writes.size(); i++)
      checkOutput($sformatf("write_byte%0d", i), 32'(writes[i]), 32'(exp_q[i]));
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int t, s, s1, f;
    reset        = 1'b1;
    init_start   = 1'b0;
    wr_fifo_full = 1'b0;
    wr_done      = 1'b0;
    wr_failure   = 1'b0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // Happy path: three entries, then entry 3 (n=0) ends the table
    $display("[TB] happy path");
    clearLog();
    startSeq(t);
    serve(50, 1'b1, 1'b0, 8'h10, 4'd1, s);
    checkOutput("start_latency_n1", s - t, 3);
    waitFlush(f);
    checkOutput("start_to_flush_e0", f - s, 50 + GAP);
    serve(50, 1'b1, 1'b0, 8'h20, 4'd2, s1);
    waitFlush(f);
    checkOutput("start_to_flush_e1", f - s1, 50 + GAP);
    serve(50, 1'b1, 1'b0, 8'h30, 4'd4, s);
    waitStatus();
    checkOutput("happy_done", 32'(init_done), 1);
    checkOutput("happy_busy", 32'(init_busy), 0);
    checkOutput("happy_error", 32'(init_error), 0);
    repeat (GAP + 10) @(negedge clk);
    checkOutput("happy_starts", starts, 3);
    checkOutput("happy_flushes", flushes, 3);
    exp_q = '{8'hA5, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
    checkWrites();

    // Retry: entry 1 fails twice before succeeding
    $display("[TB] retry");
    clearLog();
    startSeq(t);
    serve(50, 1'b1, 1'b0, 8'h10, 4'd1, s);
    serve(10, 1'b0, 1'b1, 8'h20, 4'd2, s);
    serve(10, 1'b0, 1'b1, 8'h20, 4'd2, s);
    serve(50, 1'b1, 1'b0, 8'h20, 4'd2, s);
    serve(50, 1'b1, 1'b0, 8'h30, 4'd4, s);
    waitStatus();
    checkOutput("retry_done", 32'(init_done), 1);
    checkOutput("retry_error", 32'(init_error), 0);
    @(negedge clk);
    checkOutput("retry_starts", starts, 5);
    checkOutput("retry_flushes", flushes, 5);
    exp_q = '{8'hA5, 8'hBE, 8'hEF, 8'hBE, 8'hEF, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
    checkWrites();

    // Exhaustion: every attempt at entry 2 fails
    $display("[TB] exhaustion");
    clearLog();
    startSeq(t);
    serve(50, 1'b1, 1'b0, 8'h10, 4'd1, s);
    serve(50, 1'b1, 1'b0, 8'h20, 4'd2, s);
    for (int k = 0; k < 4; k++) serve(10, 1'b0, 1'b1, 8'h30, 4'd4, s);
    waitStatus();
    checkOutput("exhaust_error", 32'(init_error), 1);
    checkOutput("exhaust_failidx", 32'(failed_index), 2);
    checkOutput("exhaust_done", 32'(init_done), 0);
    checkOutput("exhaust_busy", 32'(init_busy), 0);
    repeat (GAP + 60) @(negedge clk);
    checkOutput("exhaust_starts", starts, 6);
    checkOutput("exhaust_flushes", flushes, 6);

    // Silent abort: engine never answers, watchdog forces each retry
    $display("[TB] silent abort");
    clearLog();
    startSeq(t);
    for (int k = 0; k < 3; k++) begin
      waitStart(s);
      waitFlush(f);
      checkOutput($sformatf("watchdog_spacing%0d", k), f - s, WD + 2);
    end
    waitStart(s);
    waitStatus();
    checkOutput("abort_error", 32'(init_error), 1);
    checkOutput("abort_failidx", 32'(failed_index), 0);
    @(negedge clk);
    checkOutput("abort_starts", starts, 4);

    // Reset clears the error status
    pulseReset();
    checkOutput("reset_clears_error", 32'(init_error), 0);
    checkOutput("reset_clears_failidx", 32'(failed_index), 0);

    // Simultaneous done+failure counts as failure; FIFO full stalls a load
    $display("[TB] done/failure collision and fifo stall");
    clearLog();
    startSeq(t);
    serve(10, 1'b1, 1'b1, 8'h10, 4'd1, s);
    serve(50, 1'b1, 1'b0, 8'h10, 4'd1, s);
    serve(50, 1'b1, 1'b0, 8'h20, 4'd2, s);
    waitFlush(f);
    checkOutput("stall_entry_reg", 32'(wr_reg_address), 32'h30);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("stall_no_write%0d", k), 32'(wr_fifo_wr_en), 0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("stall_release_write", 32'(wr_fifo_wr_en), 1);
    checkOutput("stall_release_byte", 32'(wr_data), 32'h12);
    serve(50, 1'b1, 1'b0, 8'h30, 4'd4, s);
    waitStatus();
    checkOutput("collide_done", 32'(init_done), 1);
    @(negedge clk);
    checkOutput("collide_starts", starts, 4);
    checkOutput("collide_flushes", flushes, 4);
    exp_q = '{8'hA5, 8'hA5, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
    checkWrites();

    // Reset while waiting on the engine
    $display("[TB] reset in WAIT");
    startSeq(t);
    waitStart(s);
    repeat (5) @(negedge clk);
    checkOutput("wait_busy", 32'(init_busy), 1);
    checkOutput("wait_reg", 32'(wr_reg_address), 32'h10);
    pulseReset();
    checkResetValues("reset_in_wait");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
